// File: rtl/step_sequencer.sv
// 16-step programmable pattern sequencer: each accepted beat tick plays one step,
// emitting the step index, a note code and a fixed-length gate for the tone stage.
module step_sequencer #(
  parameter int unsigned GATE_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       play,
  input  logic       stop,
  input  logic [4:0] loop_len,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [3:0] step_idx,
  output logic [3:0] note,
  output logic       gate,
  output logic       bar_start
);

  localparam logic [31:0] GATE_LOAD = 32'(GATE_CYCLES);

  logic [4:0]  pat_q [16];
  logic [3:0]  ptr_q, ptr_d;
  logic [31:0] gcnt_q, gcnt_d;
  logic [3:0]  step_q, step_d;
  logic [3:0]  note_q, note_d;
  logic        gate_q, gate_d;
  logic        bar_q, bar_d;

  logic [4:0] len_eff;
  logic [3:0] sel;
  logic [4:0] sel_nxt;
  logic [4:0] sel_data;
  logic       accept;

  always_comb begin
    // Lengths of 0 or above 16 both mean the full 16-step bar.
    len_eff  = (loop_len == 5'd0 || loop_len > 5'd16) ? 5'd16 : loop_len;
    accept   = tick & play & ~stop;
    sel      = ({1'b0, ptr_q} < len_eff) ? ptr_q : 4'd0;
    sel_nxt  = {1'b0, sel} + 5'd1;
    sel_data = pat_q[sel];

    ptr_d  = ptr_q;
    gcnt_d = gcnt_q;
    step_d = step_q;
    note_d = note_q;
    gate_d = gate_q;
    bar_d  = 1'b0;

    if (stop) begin
      ptr_d  = 4'd0;
      gcnt_d = 32'd0;
      gate_d = 1'b0;
    end else if (accept) begin
      step_d = sel;
      bar_d  = (sel == 4'd0);
      ptr_d  = (sel_nxt == len_eff) ? 4'd0 : sel_nxt[3:0];
      if (sel_data[4]) begin
        note_d = sel_data[3:0];
        gcnt_d = GATE_LOAD;
        gate_d = 1'b1;
      end else begin
        gcnt_d = 32'd0;
        gate_d = 1'b0;
      end
    end else if (gcnt_q > 32'd1) begin
      gcnt_d = gcnt_q - 32'd1;
    end else if (gcnt_q == 32'd1) begin
      gcnt_d = 32'd0;
      gate_d = 1'b0;
    end
  end

  // Pattern write uses non-blocking update, so a same-cycle tick plays the old entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) pat_q[i] <= 5'd0;
      ptr_q  <= 4'd0;
      gcnt_q <= 32'd0;
      step_q <= 4'd0;
      note_q <= 4'd0;
      gate_q <= 1'b0;
      bar_q  <= 1'b0;
    end else begin
      if (wr_en) pat_q[wr_addr] <= wr_data;
      ptr_q  <= ptr_d;
      gcnt_q <= gcnt_d;
      step_q <= step_d;
      note_q <= note_d;
      gate_q <= gate_d;
      bar_q  <= bar_d;
    end
  end

  assign step_idx  = step_q;
  assign note      = note_q;
  assign gate      = gate_q;
  assign bar_start = bar_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed scenarios plus random traffic, with per-cycle
// expected outputs queued by the driver and compared by an independent monitor.
module tb_step_sequencer;

  localparam int GATE = 4;

  logic       clk = 1'b0;
  logic       reset, tick, play, stop, wr_en;
  logic [4:0] loop_len, wr_data;
  logic [3:0] wr_addr;
  logic [3:0] step_idx, note;
  logic       gate, bar_start;

  int checks = 0;
  int failures = 0;

  // Level inputs requested by the scenario; applied at the next drive slot.
  logic       rst_v, play_v;
  logic [4:0] len_v;

  // Reference model state: gate modelled as "high while edge count < gate_end".
  logic [4:0] pat_m [16];
  int         ptr_m, n, gate_end;
  logic [3:0] step_m, note_m;
  logic       bar_m;

  logic [9:0] exp_q [$];

  step_sequencer #(.GATE_CYCLES(GATE)) dut (
    .clk(clk), .reset(reset), .tick(tick), .play(play), .stop(stop),
    .loop_len(loop_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .step_idx(step_idx), .note(note), .gate(gate), .bar_start(bar_start)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pat_m[i] = 5'd0;
    ptr_m = 0; step_m = 4'd0; note_m = 4'd0; bar_m = 1'b0; gate_end = 0;
  endtask

  task automatic model_edge();
    int len, s;
    n++;
    if (reset) begin
      model_reset();
    end else begin
      len = (loop_len == 0 || loop_len > 16) ? 16 : int'(loop_len);
      bar_m = 1'b0;
      if (stop) begin
        ptr_m = 0;
        gate_end = n;
      end else if (tick && play) begin
        s = (ptr_m < len) ? ptr_m : 0;
        step_m = 4'(s);
        bar_m = (s == 0);
        ptr_m = (s + 1) % len;
        if (pat_m[s][4]) begin
          note_m = pat_m[s][3:0];
          gate_end = n + GATE;
        end else begin
          gate_end = n;
        end
      end
      if (wr_en) pat_m[wr_addr] = wr_data;
    end
    exp_q.push_back({step_m, note_m, (n < gate_end), bar_m});
  endtask

  task automatic drive(input logic t, input logic st, input logic we,
                       input logic [3:0] wa, input logic [4:0] wd);
    @(negedge clk);
    #1;
    reset = rst_v; play = play_v; loop_len = len_v;
    tick = t; stop = st; wr_en = we; wr_addr = wa; wr_data = wd;
    model_edge();
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
  endtask

  task automatic tick_gap(input int cnt, input int gap);
    repeat (cnt) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0, 5'd0);
      idle(gap);
    end
  endtask

  task automatic do_stop();
    drive(1'b0, 1'b1, 1'b0, 4'd0, 5'd0);
  endtask

  task automatic write(input logic [3:0] a, input logic [4:0] d);
    drive(1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({step_idx, note, gate, bar_start} !== 10'd0) begin
      failures++;
      $display("FAIL %s: step_idx=%0d note=%0d gate=%0b bar_start=%0b, required all 0",
               name, step_idx, note, gate, bar_start);
    end
  endtask

  // Monitor: compares every cycle's registered outputs against the queued expectation.
  always @(negedge clk) begin
    logic [9:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({step_idx, note, gate, bar_start} !== e) begin
        failures++;
        $display("FAIL out@%0t: step_idx=%0d note=%0d gate=%0b bar=%0b, required step_idx=%0d note=%0d gate=%0b bar=%0b",
                 $time, step_idx, note, gate, bar_start, e[9:6], e[5:2], e[1], e[0]);
      end
    end
  end

  initial begin
    n = 0;
    model_reset();
    rst_v = 1'b1; play_v = 1'b0; len_v = 5'd4;
    reset = 1'b1; play = 1'b0; loop_len = 5'd4;
    tick = 1'b0; stop = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 5'd0;
    #1;
    check_zero("reset_state");
    idle(2);
    rst_v = 1'b0;
    idle(2);

    // Basic sequence: notes 1..4, loop of 4, 6 ticks 10 cycles apart.
    for (int i = 0; i < 4; i++) write(4'(i), {1'b1, 4'(i + 1)});
    play_v = 1'b1;
    tick_gap(6, 9);

    // Rest on step 1.
    write(4'd1, 5'h00);
    do_stop();
    tick_gap(3, 9);

    // Retrigger: ticks two cycles apart over valid steps.
    write(4'd1, 5'h12);
    do_stop();
    tick_gap(5, 1);
    idle(8);

    // Pause, resume, stop coincident with tick.
    do_stop();
    tick_gap(3, 2);
    play_v = 1'b0;
    tick_gap(3, 1);
    idle(4);
    play_v = 1'b1;
    tick_gap(1, 5);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 5'd0);
    idle(5);
    tick_gap(1, 5);

    // Length edge cases: 0 means 16, then shorten the loop with ptr beyond it.
    for (int i = 0; i < 16; i++) write(4'(i), 5'($urandom_range(0, 31)));
    len_v = 5'd0;
    do_stop();
    tick_gap(17, 1);
    len_v = 5'd16;
    do_stop();
    tick_gap(10, 0);
    len_v = 5'd4;
    tick_gap(1, 2);

    // Write to the step being played in the same cycle.
    write(4'd0, 5'h11);
    do_stop();
    drive(1'b1, 1'b0, 1'b1, 4'd0, 5'h19);
    idle(3);
    tick_gap(4, 5);

    // Random traffic, including out-of-range lengths and rare stops.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) play_v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 30) == 0) len_v = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0),
            1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
            5'($urandom_range(0, 31)));
    end

    // Asynchronous reset while the gate is ringing.
    play_v = 1'b1;
    len_v = 5'd4;
    write(4'd0, 5'h17);
    do_stop();
    tick_gap(1, 1);
    @(negedge clk);
    #1;
    checks++;
    if (gate !== 1'b1) begin
      failures++;
      $display("FAIL gate_before_reset: gate=%0b, required 1", gate);
    end
    reset = 1'b1;
    rst_v = 1'b1;
    #1;
    check_zero("async_reset_mid_gate");
    model_reset();
    idle(2);
    rst_v = 1'b0;
    idle(1);
    write(4'd0, 5'h1a);
    tick_gap(1, 5);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
# step_sequencer

Pattern step sequencer that consumes the beat-enable pulse produced by the bpm tick generator (`bpm_out`, one pulse per half-beat, quarter/eighth alternating). Each accepted tick plays one step of a 16-step programmable pattern, producing a note code and a timed gate for the downstream tone/audio stage. The pattern is written by the user-input front end through a simple write port. Position is held while paused and cleared on stop.

## Interface
- `GATE_CYCLES`, default 5_000_000: gate-high duration in clk cycles (100 ms at 50 MHz); legal range 1..2^32-1.
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  single-cycle step enable; connects to `bpm_out`.
- `play`  in  1  level; 1 = run, 0 = pause (position held).
- `stop`  in  1  single-cycle; returns the play pointer to step 0.
- `loop_len`  in  5  active steps 1..16; 0 is treated as 16; values 17..31 are treated as 16.
- `wr_en`  in  1  pattern write strobe.
- `wr_addr`  in  4  step to write.
- `wr_data`  in  5  {valid, note[3:0]}; valid=0 marks a rest.
- `step_idx`  out  4  index of the step most recently played.
- `note`  out  4  note code of the most recent valid step.
- `gate`  out  1  note-on, high for `GATE_CYCLES` cycles after a valid step.
- `bar_start`  out  1  single-cycle pulse when step 0 is played.

## Operation
- Storage: 16 x 5-bit pattern registers; all cleared to 0 (rests) by reset.
- Internal state: play pointer `ptr[3:0]`, gate down-counter `gcnt[31:0]`.
- Accepted tick: `tick & play & !stop`. Ticks while `play`=0 are discarded, not queued.
- On an accepted tick:
  - Select step `s = (ptr < L) ? ptr : 0`, where L is the effective length.
  - Set `step_idx <= s`.
  - Set `bar_start <= (s == 0)`.
  - Set `ptr <= (s+1 == L) ? 0 : s+1`.
  - If `pattern[s].valid`: `note <= pattern[s].note`, `gcnt <= GATE_CYCLES`, `gate <= 1`.
  - If the step is a rest: `note` holds, `gcnt <= 0`, `gate <= 0`. A rest cuts any ringing gate.
- Retrigger: a valid step arriving while `gate`=1 reloads `gcnt`. `gate` stays continuously high and `note` updates.
- Gate countdown: each cycle with `gcnt` > 1, decrement. When `gcnt` == 1, it becomes 0 and `gate` drops on that same edge.
- `stop`: `ptr <= 0`, `gate <= 0`, `gcnt <= 0`. `step_idx` and `note` hold. Stop wins over a simultaneous tick.
- Pause (`play`=0): `ptr` holds. The gate countdown continues and completes normally.
- Writes: `pattern[wr_addr] <= wr_data` on any cycle, independent of `play`.
  - Write and tick in the same cycle to the same step: the old data is played; the new data is used on the next visit.
- `loop_len` change mid-run takes effect on the next accepted tick through the `ptr < L` rule above.

## Timing
- All outputs are registered.
- Latency: tick sampled at edge n; `step_idx`, `note`, `gate`, `bar_start` update at edge n (visible in cycle n+1).
- `gate` high duration: exactly `GATE_CYCLES` cycles, with no retrigger.
- `bar_start` is high for one cycle only, and even with L=1 it never stays high across consecutive cycles (ticks are single-cycle).
- Reset values (asynchronous, immediate on assertion):
  - `step_idx` = 0, `note` = 0, `gate` = 0, `bar_start` = 0.
  - `ptr` = 0, `gcnt` = 0.
  - Pattern all 0.
- Reset mid-gate drops `gate` immediately. The first accepted tick after reset plays step 0.
- Wrap-around: with L=16, step 15 is followed by step 0. `ptr` arithmetic is 4-bit; the L=16 comparison uses 5-bit.

## Test plan
Benches use `GATE_CYCLES`=4.
- **Basic sequence:** write steps 0..3 as notes 1,2,3,4 (all valid); `loop_len`=4; `play`=1; apply 6 ticks, 10 cycles apart.
  - Required: `step_idx` 0,1,2,3,0,1 and `note` 1,2,3,4,1,2.
  - `gate` high exactly 4 cycles after each tick.
  - `bar_start` pulses on ticks 1 and 5.
- **Rest handling:** step 1 = rest (`wr_data`=5'h00).
  - Required: on the tick for step 1, `gate` = 0, `note` holds 1, `step_idx` = 1.
- **Retrigger:** ticks 2 cycles apart on valid steps.
  - Required: `gate` stays high continuously; it drops 4 cycles after the last tick.
- **Pause/stop:** after step 2, set `play`=0 and apply 3 ticks.
  - Required: no output change; the gate finishes its countdown.
  - Then `play`=1 and a tick: plays step 3.
  - Then `stop` coincident with a tick: no step played, `gate`=0; the next tick plays step 0.
- **Length edge cases:** `loop_len`=0, run 17 ticks: steps 0..15 then 0.
  - With `ptr`=10, change `loop_len` to 4; next tick plays step 0.
- **Reset and write collision:**
  - Write step 0 to note 9 on the same cycle as a tick playing step 0: note outputs the old value; the next visit plays 9.
  - Assert `reset` mid-gate: all outputs 0 asynchronously, before the next clk edge.
